// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - push-button synchroniser, debouncer, edge pulses, toggle and long-press detector
module button_debouncer #(
    parameter int SYNC_STAGES_P       = 2,
    parameter int DEBOUNCE_CYCLES_P   = 1250000,
    parameter int LONG_PRESS_CYCLES_P = 125000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_db,
    output logic btn_press,
    output logic btn_release,
    output logic btn_tgl,
    output logic long_press
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES_P);
    localparam int LP_W = $clog2(LONG_PRESS_CYCLES_P + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES_P - 1);
    localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS_CYCLES_P);
    localparam logic [LP_W-1:0] LP_PRE  = LP_W'(LONG_PRESS_CYCLES_P - 1);

    logic [SYNC_STAGES_P-1:0] sync_q;
    logic                     btn_s;
    logic [DB_W-1:0]          db_cnt;
    logic [LP_W-1:0]          lp_cnt;
    logic                     accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES_P-2:0], btn};
        end
    end

    assign btn_s  = sync_q[SYNC_STAGES_P-1];
    // New level is taken on the last cycle of an unbroken disagreement run
    assign accept = (btn_s != btn_db) && (db_cnt == DB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            btn_db <= 1'b0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (accept) begin
            db_cnt <= '0;
            btn_db <= btn_s;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_tgl     <= 1'b0;
        end else begin
            btn_press   <= accept & btn_s;
            btn_release <= accept & ~btn_s;
            if (accept && btn_s) begin
                btn_tgl <= ~btn_tgl;
            end
        end
    end

    // Saturating hold counter makes long_press one-shot per press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_cnt     <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= btn_db && (lp_cnt == LP_PRE);
            if (!btn_db) begin
                lp_cnt <= '0;
            end else if (lp_cnt != LP_MAX) begin
                lp_cnt <= lp_cnt + LP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed self-checking bench for button_debouncer
module tb_button_debouncer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;
    logic btn_db, btn_press, btn_release, btn_tgl, long_press;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int press_cnt = 0, release_cnt = 0, lp_cnt = 0, both_cnt = 0;
    int press_cyc = 0, lp_cyc = 0;

    button_debouncer #(
        .SYNC_STAGES_P      (2),
        .DEBOUNCE_CYCLES_P  (8),
        .LONG_PRESS_CYCLES_P(32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .btn_db     (btn_db),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_tgl    (btn_tgl),
        .long_press (long_press)
    );

    always #5 clk = ~clk;

    // Event monitor: counts posedges and pulse occurrences, sampled 1 ns after the edge
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (btn_press) begin
            press_cnt = press_cnt + 1;
            press_cyc = cyc;
        end
        if (btn_release) release_cnt = release_cnt + 1;
        if (long_press) begin
            lp_cnt = lp_cnt + 1;
            lp_cyc = cyc;
        end
        if (btn_press && btn_release) both_cnt = both_cnt + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wait_cycles(3);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn   = 1'b0;
        wait_cycles(3);
        checks++; if (btn_db !== 1'b0)      begin errors++; $display("FAIL reset_btn_db got=%b exp=0", btn_db); end
        checks++; if (btn_press !== 1'b0)   begin errors++; $display("FAIL reset_btn_press got=%b exp=0", btn_press); end
        checks++; if (btn_release !== 1'b0) begin errors++; $display("FAIL reset_btn_release got=%b exp=0", btn_release); end
        checks++; if (btn_tgl !== 1'b0)     begin errors++; $display("FAIL reset_btn_tgl got=%b exp=0", btn_tgl); end
        checks++; if (long_press !== 1'b0)  begin errors++; $display("FAIL reset_long_press got=%b exp=0", long_press); end
        rst_n = 1'b1;
        wait_cycles(5);
    endtask

    task automatic test_clean_press();
        int start, p0, r0;
        start = cyc; p0 = press_cnt; r0 = release_cnt;
        btn = 1'b1;
        wait_cycles(9);
        checks++; if (btn_db !== 1'b0) begin errors++; $display("FAIL clean_early_db got=%b exp=0", btn_db); end
        wait_cycles(1);
        checks++; if (btn_db !== 1'b1)    begin errors++; $display("FAIL clean_db_rise got=%b exp=1", btn_db); end
        checks++; if (btn_press !== 1'b1) begin errors++; $display("FAIL clean_press_high got=%b exp=1", btn_press); end
        wait_cycles(1);
        checks++; if (btn_press !== 1'b0) begin errors++; $display("FAIL clean_press_width got=%b exp=0", btn_press); end
        wait_cycles(5);
        checks++; if (press_cnt - p0 != 1)    begin errors++; $display("FAIL clean_press_count got=%0d exp=1", press_cnt - p0); end
        checks++; if (press_cyc - start != 10) begin errors++; $display("FAIL clean_latency got=%0d exp=10", press_cyc - start); end
        checks++; if (btn_tgl !== 1'b1)       begin errors++; $display("FAIL clean_tgl got=%b exp=1", btn_tgl); end
        checks++; if (release_cnt != r0)      begin errors++; $display("FAIL clean_no_release got=%0d exp=%0d", release_cnt, r0); end
        btn = 1'b0;
        wait_cycles(15);
        checks++; if (btn_db !== 1'b0)          begin errors++; $display("FAIL clean_db_fall got=%b exp=0", btn_db); end
        checks++; if (release_cnt - r0 != 1)    begin errors++; $display("FAIL clean_release_count got=%0d exp=1", release_cnt - r0); end
    endtask

    task automatic test_glitch();
        int p0;
        p0 = press_cnt;
        btn = 1'b1;
        wait_cycles(5);
        btn = 1'b0;
        wait_cycles(20);
        checks++; if (press_cnt != p0)  begin errors++; $display("FAIL glitch_press got=%0d exp=%0d", press_cnt, p0); end
        checks++; if (btn_db !== 1'b0)  begin errors++; $display("FAIL glitch_db got=%b exp=0", btn_db); end
        checks++; if (btn_tgl !== 1'b1) begin errors++; $display("FAIL glitch_tgl got=%b exp=1", btn_tgl); end
    endtask

    task automatic test_bounce();
        int start, p0, l0;
        p0 = press_cnt; l0 = lp_cnt;
        for (int i = 0; i < 40; i++) begin
            btn = ((i / 3) % 2 == 0);
            @(negedge clk);
        end
        checks++; if (press_cnt != p0) begin errors++; $display("FAIL bounce_early_press got=%0d exp=%0d", press_cnt, p0); end
        btn = 1'b1;
        start = cyc;
        wait_cycles(20);
        checks++; if (press_cnt - p0 != 1)     begin errors++; $display("FAIL bounce_press_count got=%0d exp=1", press_cnt - p0); end
        checks++; if (press_cyc - start != 10) begin errors++; $display("FAIL bounce_latency got=%0d exp=10", press_cyc - start); end
        checks++; if (btn_tgl !== 1'b0)        begin errors++; $display("FAIL bounce_tgl got=%b exp=0", btn_tgl); end
        btn = 1'b0;
        wait_cycles(20);
        checks++; if (lp_cnt != l0) begin errors++; $display("FAIL bounce_long_press got=%0d exp=%0d", lp_cnt, l0); end
    endtask

    task automatic test_long_press();
        int l0, r0;
        l0 = lp_cnt; r0 = release_cnt;
        btn = 1'b1;
        wait_cycles(60);
        checks++; if (lp_cnt - l0 != 1)          begin errors++; $display("FAIL long_count got=%0d exp=1", lp_cnt - l0); end
        checks++; if (lp_cyc - press_cyc != 32)  begin errors++; $display("FAIL long_delay got=%0d exp=32", lp_cyc - press_cyc); end
        checks++; if (btn_db !== 1'b1)           begin errors++; $display("FAIL long_db got=%b exp=1", btn_db); end
        btn = 1'b0;
        wait_cycles(20);
        checks++; if (release_cnt - r0 != 1) begin errors++; $display("FAIL long_release got=%0d exp=1", release_cnt - r0); end
        checks++; if (lp_cnt - l0 != 1)      begin errors++; $display("FAIL long_refire got=%0d exp=1", lp_cnt - l0); end
    endtask

    task automatic test_back_to_back();
        int p0, l0;
        apply_reset();
        p0 = press_cnt; l0 = lp_cnt;
        checks++; if (btn_tgl !== 1'b0) begin errors++; $display("FAIL b2b_tgl_start got=%b exp=0", btn_tgl); end
        btn = 1'b1;
        wait_cycles(20);
        checks++; if (btn_tgl !== 1'b1) begin errors++; $display("FAIL b2b_tgl_first got=%b exp=1", btn_tgl); end
        btn = 1'b0;
        wait_cycles(20);
        btn = 1'b1;
        wait_cycles(20);
        checks++; if (btn_tgl !== 1'b0) begin errors++; $display("FAIL b2b_tgl_second got=%b exp=0", btn_tgl); end
        btn = 1'b0;
        wait_cycles(20);
        checks++; if (press_cnt - p0 != 2) begin errors++; $display("FAIL b2b_press_count got=%0d exp=2", press_cnt - p0); end
        checks++; if (lp_cnt != l0)        begin errors++; $display("FAIL b2b_long_press got=%0d exp=%0d", lp_cnt, l0); end
    endtask

    task automatic test_reset_mid();
        int start, p0;
        btn = 1'b1;
        wait_cycles(20);
        btn = 1'b0;
        wait_cycles(20);
        checks++; if (btn_tgl !== 1'b1) begin errors++; $display("FAIL mid_setup_tgl got=%b exp=1", btn_tgl); end
        btn = 1'b1;
        wait_cycles(7);
        rst_n = 1'b0;
        #1;
        checks++; if (btn_db !== 1'b0)      begin errors++; $display("FAIL mid_rst_db got=%b exp=0", btn_db); end
        checks++; if (btn_tgl !== 1'b0)     begin errors++; $display("FAIL mid_rst_tgl got=%b exp=0", btn_tgl); end
        checks++; if (btn_press !== 1'b0)   begin errors++; $display("FAIL mid_rst_press got=%b exp=0", btn_press); end
        checks++; if (btn_release !== 1'b0) begin errors++; $display("FAIL mid_rst_release got=%b exp=0", btn_release); end
        checks++; if (long_press !== 1'b0)  begin errors++; $display("FAIL mid_rst_long got=%b exp=0", long_press); end
        wait_cycles(2);
        p0 = press_cnt;
        rst_n = 1'b1;
        start = cyc;
        wait_cycles(15);
        checks++; if (press_cnt - p0 != 1)     begin errors++; $display("FAIL mid_press_count got=%0d exp=1", press_cnt - p0); end
        checks++; if (press_cyc - start != 10) begin errors++; $display("FAIL mid_latency got=%0d exp=10", press_cyc - start); end
        checks++; if (btn_tgl !== 1'b1)        begin errors++; $display("FAIL mid_tgl got=%b exp=1", btn_tgl); end
        checks++; if (btn_db !== 1'b1)         begin errors++; $display("FAIL mid_db got=%b exp=1", btn_db); end
        btn = 1'b0;
        wait_cycles(20);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_long_press();
        test_back_to_back();
        test_reset_mid();
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL press_release_overlap got=%0d exp=0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
